cmp_sort_seq: RTL



---
 rtl/cmp_sort_seq.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/cmp_sort_seq.sv
// Sequential bubble sorter: loads DEPTH words, sorts them with one shared
// unsigned comparison per clock (early exit on a clean pass), then streams them out.
module cmp_sort_seq #(
  parameter int N     = 8,
  parameter int DEPTH = 8,
  parameter bit DESC  = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic         sort_done
);

  localparam int IW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(DEPTH - 1);
  localparam logic [IW-1:0] LAST_PAIR = IW'(DEPTH - 2);

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    DRAIN
  } state_t;

  state_t        state;
  logic [N-1:0]  mem [DEPTH];
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] idx;
  logic [IW-1:0] pass;
  logic          pass_swapped;

  logic [IW-1:0] idx_nxt;
  logic [IW-1:0] rd_nxt;
  logic [N-1:0]  a_word;
  logic [N-1:0]  b_word;
  logic          a_gt_b;
  logic          a_lt_b;
  logic          swap;
  logic          pass_end;
  logic          sort_fin;
  logic [N-1:0]  head_after;

  // Shared comparator on the current adjacent pair; equal words never swap.
  always_comb begin
    idx_nxt    = idx + IW'(1);
    rd_nxt     = rd_idx + IW'(1);
    a_word     = mem[idx];
    b_word     = mem[idx_nxt];
    a_gt_b     = (a_word > b_word);
    a_lt_b     = (a_word < b_word);
    swap       = DESC ? a_lt_b : a_gt_b;
    pass_end   = (idx == LAST_PAIR);
    sort_fin   = pass_end && ((!pass_swapped && !swap) || (pass == LAST_PAIR));
    // Word 0 as it will be after this edge; only differs when DEPTH is 2.
    head_after = (swap && (idx == '0)) ? b_word : mem[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LOAD;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_idx       <= '0;
      rd_idx       <= '0;
      idx          <= '0;
      pass         <= '0;
      pass_swapped <= 1'b0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
      busy         <= 1'b0;
      sort_done    <= 1'b0;
    end else begin
      sort_done <= 1'b0;
      unique case (state)
        LOAD: begin
          if (in_valid) begin
            mem[wr_idx] <= in_data;
            if (wr_idx == LAST_IDX) begin
              wr_idx       <= '0;
              idx          <= '0;
              pass         <= '0;
              pass_swapped <= 1'b0;
              state        <= SORT;
              in_ready     <= 1'b0;
              busy         <= 1'b1;
            end else begin
              wr_idx <= wr_idx + IW'(1);
            end
          end
        end

        SORT: begin
          if (swap) begin
            mem[idx]     <= b_word;
            mem[idx_nxt] <= a_word;
            pass_swapped <= 1'b1;
          end
          if (sort_fin) begin
            state     <= DRAIN;
            busy      <= 1'b0;
            sort_done <= 1'b1;
            out_valid <= 1'b1;
            out_data  <= head_after;
            out_last  <= (LAST_IDX == '0);
            rd_idx    <= '0;
          end else if (pass_end) begin
            idx          <= '0;
            pass         <= pass + IW'(1);
            pass_swapped <= 1'b0;
          end else begin
            idx <= idx_nxt;
          end
        end

        DRAIN: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= LOAD;
              rd_idx    <= '0;
              pass      <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              in_ready  <= 1'b1;
            end else begin
              rd_idx   <= rd_nxt;
              out_data <= mem[rd_nxt];
              out_last <= (rd_nxt == LAST_IDX);
            end
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

endmodule
